// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronised ro_in rises over contiguous
// GATE_CYCLES windows. Define RO_AVG_EN to present the average of every 4 windows.
`timescale 1ns/1ps
module ro_freq_counter #(
  parameter int unsigned GATE_CYCLES = 100000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             en,
  input  logic             ovr_clr,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun
);

  localparam int unsigned       GateW  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GateW-1:0]  GLast  = GateW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StGate} state_e;

  state_e             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_dly;
  logic [GateW-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]   r_edge_cnt;

  logic               w_rise;
  logic               w_terminal;
  logic               w_present;
  logic               w_accept;
  logic [CNT_W-1:0]   w_result;
  logic [CNT_W-1:0]   w_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= ro_in;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign w_rise     = r_sync2 & ~r_dly;
  assign w_terminal = (r_state == StGate) && en && (r_gate_cnt == GLast);
  // The rise seen on the terminal cycle still belongs to this window.
  assign w_result   = (w_rise && (r_edge_cnt != CntMax)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;

`ifdef RO_AVG_EN
  logic [CNT_W+1:0] r_acc;
  logic [1:0]       r_win_idx;
  logic [CNT_W+1:0] w_sum;

  assign w_sum     = r_acc + {2'b00, w_result};
  assign w_present = w_terminal && (r_win_idx == 2'd3);
  assign w_sample  = CNT_W'(w_sum >> 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_win_idx <= '0;
    end else if ((r_state != StGate) || !en) begin
      r_acc     <= '0;
      r_win_idx <= '0;
    end else if (w_terminal) begin
      r_acc     <= w_present ? '0 : w_sum;
      r_win_idx <= r_win_idx + 2'd1;
    end
  end
`else
  assign w_present = w_terminal;
  assign w_sample  = w_result;
`endif

  assign w_accept = ~cnt_valid | cnt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      cnt_data   <= '0;
      cnt_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          if (en) r_state <= StGate;
        end
        StGate: begin
          if (!en) begin
            r_state    <= StIdle;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
          end else if (w_terminal) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
          end else begin
            r_gate_cnt <= r_gate_cnt + GateW'(1);
            r_edge_cnt <= w_result;
          end
        end
      endcase

      if (w_present && w_accept) begin
        cnt_data  <= w_sample;
        cnt_valid <= 1'b1;
      end else if (cnt_valid && cnt_ready) begin
        cnt_valid <= 1'b0;
      end

      // A drop in the same cycle as ovr_clr keeps the flag set.
      if (w_present && !w_accept) overrun <= 1'b1;
      else if (ovr_clr)           overrun <= 1'b0;
    end
  end

endmodule
